// File: rtl/icache_sa_pkg.sv
// Shared types and helpers for the set-associative instruction cache.
package icache_sa_pkg;

  localparam int INSTR_W    = 32;
  localparam int ADDR_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Bit width needed to index n items, never less than one bit.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/icache_way.sv
// One cache way: valid/tag/data arrays, lookup tag compare and word select,
// and the refill write port.
module icache_way
  import icache_sa_pkg::*;
#(
  parameter int SETS      = 16,
  parameter int BLK_INSTR = 4,
  parameter int TAG_W     = 24,
  parameter int IDX_W     = 4,
  parameter int WSEL_W    = 2
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic                           clr_in,
  input  logic [IDX_W-1:0]               rd_idx_in,
  input  logic [TAG_W-1:0]               rd_tag_in,
  input  logic [WSEL_W-1:0]              rd_wsel_in,
  output logic                           hit_out,
  output logic [INSTR_W-1:0]             word_out,
  input  logic [IDX_W-1:0]               fill_idx_in,
  output logic                           fill_vld_out,
  input  logic                           wr_en_in,
  input  logic [TAG_W-1:0]               wr_tag_in,
  input  logic [BLK_INSTR*INSTR_W-1:0]   wr_data_in
);

  logic [SETS-1:0]              vld_q, vld_d;
  logic [TAG_W-1:0]             tag_q  [SETS];
  logic [BLK_INSTR*INSTR_W-1:0] data_q [SETS];

  // Clear wins over a same-cycle fill.
  always_comb begin
    vld_d = vld_q;
    if (clr_in)
      vld_d = '0;
    else if (wr_en_in)
      vld_d[fill_idx_in] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst_in)
      vld_q <= '0;
    else
      vld_q <= vld_d;
  end

  always_ff @(posedge clk) begin
    if (wr_en_in) begin
      tag_q[fill_idx_in]  <= wr_tag_in;
      data_q[fill_idx_in] <= wr_data_in;
    end
  end

  assign hit_out      = vld_q[rd_idx_in] && (tag_q[rd_idx_in] == rd_tag_in);
  assign word_out     = data_q[rd_idx_in][rd_wsel_in*INSTR_W +: INSTR_W];
  assign fill_vld_out = vld_q[fill_idx_in];

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with combinational lookup, a single
// outstanding block refill, round-robin victim selection and whole-cache flush.
//
// state   | meaning
// IDLE    | no refill in flight; a fetch miss latches its block address
// REQ     | first cycle of the memory request
// WAIT    | request held until mem_in_en returns the block
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int WAYS      = 2,
  parameter int SETS      = 16,
  parameter int BLK_INSTR = 4
) (
  input  logic                           clk,
  input  logic                           rst_in,
  input  logic                           flush_in,
  input  logic                           if_en_in,
  input  logic [ADDR_W-1:0]              if_ain,
  output logic                           if_out_en,
  output logic [INSTR_W-1:0]             if_instr_out,
  output logic                           miss,
  output logic                           mem_req_out,
  output logic [ADDR_W-1:0]              mem_aout,
  input  logic                           mem_in_en,
  input  logic [BLK_INSTR*INSTR_W-1:0]   mem_din
);

  localparam int OFF_W  = $clog2(BLK_INSTR) + 2;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
  localparam int BLKA_W = ADDR_W - OFF_W;
  localparam int WSEL_W = clog2_min1(BLK_INSTR);
  localparam int RR_W   = clog2_min1(WAYS);

  state_e            state_q, state_d;
  logic [BLKA_W-1:0] blk_q, blk_d;
  logic              drop_q, drop_d;
  logic [RR_W-1:0]   rr_q [SETS];
  logic [RR_W-1:0]   rr_d [SETS];

  logic [IDX_W-1:0]  idx, fill_idx;
  logic [TAG_W-1:0]  tag, fill_tag;
  logic [WSEL_W-1:0] wsel;
  logic [WAYS-1:0]   way_hit, way_vld, way_we;
  logic [INSTR_W-1:0] way_word [WAYS];
  logic [INSTR_W-1:0] hit_word;
  logic [RR_W-1:0]   victim;
  logic              hit, busy, fill_we;
  logic              unused_lsb;

  assign idx        = if_ain[OFF_W +: IDX_W];
  assign tag        = if_ain[ADDR_W-1 -: TAG_W];
  assign fill_idx   = blk_q[IDX_W-1:0];
  assign fill_tag   = blk_q[BLKA_W-1 -: TAG_W];
  assign unused_lsb = ^if_ain[1:0];

  if (BLK_INSTR > 1) begin : g_wsel
    assign wsel = if_ain[2 +: WSEL_W];
  end else begin : g_wsel1
    assign wsel = '0;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .SETS      (SETS),
      .BLK_INSTR (BLK_INSTR),
      .TAG_W     (TAG_W),
      .IDX_W     (IDX_W),
      .WSEL_W    (WSEL_W)
    ) u_way (
      .clk          (clk),
      .rst_in       (rst_in),
      .clr_in       (flush_in),
      .rd_idx_in    (idx),
      .rd_tag_in    (tag),
      .rd_wsel_in   (wsel),
      .hit_out      (way_hit[w]),
      .word_out     (way_word[w]),
      .fill_idx_in  (fill_idx),
      .fill_vld_out (way_vld[w]),
      .wr_en_in     (way_we[w]),
      .wr_tag_in    (fill_tag),
      .wr_data_in   (mem_din)
    );
  end

  assign hit     = if_en_in && (|way_hit);
  assign busy    = (state_q != ST_IDLE);
  assign fill_we = busy && mem_in_en && !drop_q && !flush_in;

  // Fill guarantees a single matching way, so OR-ing the hit words is a mux.
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (way_hit[w]) hit_word = hit_word | way_word[w];
  end

  // Descending scan so the lowest-index invalid way wins over the pointer.
  always_comb begin
    victim = (WAYS > 1) ? rr_q[fill_idx] : '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_vld[w]) victim = RR_W'(w);
    for (int w = 0; w < WAYS; w++)
      way_we[w] = fill_we && (victim == RR_W'(w));
  end

  always_comb begin
    rr_d = rr_q;
    if (flush_in) begin
      for (int s = 0; s < SETS; s++) rr_d[s] = '0;
    end else if (fill_we && (WAYS > 1)) begin
      rr_d[fill_idx] = rr_q[fill_idx] + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_in) begin
      state_q <= ST_IDLE;
      blk_q   <= '0;
      drop_q  <= 1'b0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      state_q <= state_d;
      blk_q   <= blk_d;
      drop_q  <= drop_d;
      rr_q    <= rr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    blk_d   = blk_q;
    drop_d  = drop_q;
    case (state_q)
      ST_IDLE: begin
        if (if_en_in && !hit && !flush_in) begin
          state_d = ST_REQ;
          blk_d   = if_ain[ADDR_W-1:OFF_W];
        end
      end
      ST_REQ:  state_d = mem_in_en ? ST_IDLE : ST_WAIT;
      ST_WAIT: if (mem_in_en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A flushed refill still finishes its handshake, then the flag clears.
    if (busy && mem_in_en)
      drop_d = 1'b0;
    else if (busy && flush_in)
      drop_d = 1'b1;
  end

  always_comb begin
    if_out_en    = hit;
    if_instr_out = hit ? hit_word : '0;
    miss         = if_en_in && !hit;
    mem_req_out  = busy;
    mem_aout     = {blk_q, {OFF_W{1'b0}}};
  end

endmodule

// File: doc/icache_sa.md
Name: icache_sa

Overview:
- Parametrised set-associative instruction cache; successor to the direct-mapped iCache between instruction fetch and the memory controller.
- Combinational hit lookup, same cycle as the fetch address.
- Owns its refill: a FSM issues block-aligned requests to memory and installs the returned block into a victim way.
- Supports a whole-cache flush (for fence.i and debug reload).

Parameters:
- ADDR_W, 32, fetch/memory address width.
- WAYS, 2, associativity; power of two, 1..8.
- SETS, 16, sets per way; power of two, >=2.
- BLK_INSTR, 4, 32-bit instructions per block; power of two, >=1.

Ports:
- clk  in  1  system clock.
- rst_in  in  1  synchronous active-high reset.
- flush_in  in  1  invalidate all lines (1-cycle pulse).
- if_en_in  in  1  fetch request valid.
- if_ain  in  ADDR_W  fetch byte address; bits[1:0] ignored.
- if_out_en  out  1  hit: if_instr_out valid this cycle.
- if_instr_out  out  32  instruction at if_ain.
- miss  out  1  if_en_in && !hit.
- mem_req_out  out  1  refill request, level.
- mem_aout  out  ADDR_W  block-aligned refill address.
- mem_in_en  in  1  refill data valid, 1-cycle pulse.
- mem_din  in  BLK_INSTR*32  refill block; instr k at bits [32k+31:32k].

Behaviour:
- Address split:
  - OFF = log2(BLK_INSTR)+2 low bits (word select = [OFF-1:2]).
  - IDX = log2(SETS) bits next.
  - TAG = remainder.
- Lookup (combinational):
  - hit = if_en_in && any way w with valid[w][idx] && tag[w][idx]==tag.
  - if_out_en = hit; if_instr_out = selected word of the hit way, else 0.
  - At most one way may match; the fill logic guarantees this.
- FSM states: IDLE, REQ, WAIT.
  - IDLE: if_en_in && !hit && !flush_in -> latch block address (if_ain with low OFF bits zeroed) and idx -> REQ.
  - REQ: mem_req_out=1, mem_aout=latched address; go to WAIT next cycle, with mem_req_out held high.
  - WAIT: mem_req_out=1 until mem_in_en.
    - On mem_in_en: write data/tag, set valid in the victim way, update the set's replacement pointer -> IDLE.
    - A mem_in_en arriving in REQ is treated identically (zero-latency memory).
  - mem_in_en in IDLE is ignored; no state change, no write.
- Fill timing:
  - Written line is visible from the cycle after mem_in_en.
  - Refill miss-to-hit latency = memory latency + 1 cycle minimum.
  - Requester holds if_ain; the cache does not buffer fetches.
- Victim selection:
  - Lowest-index invalid way in the set.
  - If none is invalid, the per-set round-robin pointer rr[idx] (log2(WAYS) bits, wraps WAYS-1 -> 0), incremented on every fill into that set.
  - WAYS=1 degenerates to direct-mapped; no pointer.
- While not IDLE: lookups still report hits; misses do not start new refills (single outstanding refill). miss output still reflects lookup.
- flush_in:
  - Clears all valid bits next edge; rr pointers reset to 0.
  - If in REQ/WAIT, set drop flag: the pending fill completes the handshake but writes nothing; FSM returns to IDLE.
  - Flush has priority over a same-cycle fill to any set.
  - Hit output in the flush cycle is still computed from pre-flush state.
- Reset (any state, including mid-refill):
  - FSM=IDLE, mem_req_out=0, mem_aout=0, all valid=0, rr=0, drop=0.
  - Tags/data need no reset.
  - if_out_en=0 after reset since no line is valid.

Decomposition:
- Shared package/param header: ADDR_W default, instruction width 32, derived OFF/IDX/TAG widths and range macros, FSM state encodings.
- One natural sub-module: icache_way (one way's valid/tag/data arrays, tag compare, word select, write port), instantiated WAYS times via generate.
- Victim select, FSM and output mux live in the top.

Test Plan:
- Cold miss, WAYS=2, SETS=16, BLK_INSTR=4, fetch 0x0000_1004:
  - Required: miss=1; mem_req_out=1 with mem_aout=0x0000_1000 the following cycle.
  - mem_din returned 3 cycles later with word1=0x00A00093; next cycle if_out_en=1, if_instr_out=0x00A00093.
- Conflict fill of the same set: fill 0x1000 then 0x2000 (both idx 0).
  - Required: both hit afterwards (ways 0 and 1).
  - Fetching 0x3000 evicts way 0 (rr=0); 0x1000 then misses and 0x2000 still hits.
- Round-robin wrap:
  - Required: a fourth conflicting fill evicts way 1; rr returns to 0.
- Flush during WAIT for 0x4000:
  - flush_in pulse, then mem_in_en.
  - Required: no line written, FSM IDLE, all prior hits now miss.
- Reset mid-refill (rst_in in WAIT):
  - Required: next cycle mem_req_out=0, if_out_en=0; a later stray mem_in_en is ignored.
- Hit during refill:
  - Fetch a resident address while WAIT for another block.
  - Required: if_out_en=1 with the correct instruction; mem_aout unchanged.
